// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute and drives datapath strobes.
// Define MIPS_CTRL_JUMP_EN to decode J through the JUMP state; otherwise J is treated as illegal.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MIPS_CTRL_JUMP_EN
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        illegal_d   = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // Fetch strobes follow the memory handshake but must stay quiet while reset is held
                IRWrite = MemReady & ~reset;
                PCWrite = MemReady & ~reset;
                state_d = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MIPS_CTRL_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
`ifdef MIPS_CTRL_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            // Unused codes (and JUMP when jumps are disabled) recover to FETCH with everything low
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign Illegal = illegal_q;
    assign State   = state_q;

endmodule
